line_clear_ctrl: RTL and testbench

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/line_clear_ctrl_if.sv | 29 ++
 rtl/line_clear_ctrl.sv | 167 ++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_ctrl_if.sv
// Board-access and control bundle for line_clear_ctrl.
// master: the clear controller (drives board addresses/writes, status).
// slave : the environment (issues start, serves board reads).
interface line_clear_ctrl_if;
  logic       start;
  logic       board_rdata;
  logic [3:0] board_rx;
  logic [4:0] board_ry;
  logic       board_we;
  logic [3:0] board_wx;
  logic [4:0] board_wy;
  logic       board_wdata;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
  logic [7:0] score;

  modport master (
    input  start, board_rdata,
    output board_rx, board_ry, board_we, board_wx, board_wy, board_wdata,
    output busy, done, lines_cleared, score
  );

  modport slave (
    output start, board_rdata,
    input  board_rx, board_ry, board_we, board_wx, board_wy, board_wdata,
    input  busy, done, lines_cleared, score
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Line-clear controller for a 10x20 board (row 19 at the bottom).
// Scans rows bottom-up, drops full rows by copying the remaining rows down,
// then zero-fills the vacated rows at the top.
// Optional macro LINE_CLEAR_SCORE_EN adds a saturating 8-bit score accumulator;
// without it score is tied to 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// SCAN   | reading row src one cell per cycle, AND-accumulating occupancy
// COPY   | copying row src onto row dst, one cell per cycle
// FILL   | writing 0 to rows cnt-1 .. 0, pointer held in dst
// DONE   | one-cycle completion pulse
module line_clear_ctrl (
  input  logic              CLOCK_50,
  input  logic              reset,
  line_clear_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_COPY = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] COL_LAST = 4'd9;
  localparam logic [4:0] ROW_LAST = 5'd19;
  localparam logic [4:0] CNT_MAX  = 5'd20;

  logic [2:0] state_q, state_d;
  logic [4:0] src_q, src_d;
  logic [4:0] dst_q, dst_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] col_q, col_d;
  logic       full_q, full_d;

  logic       col_end;
  logic       row_full;
  logic [4:0] cnt_inc;
  logic       in_scan, in_copy, in_fill;

  assign col_end  = (col_q == COL_LAST);
  // Column 0 starts a fresh AND so the previous row's result never leaks in.
  assign row_full = ((col_q == 4'd0) ? 1'b1 : full_q) & bus.board_rdata;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;

  // Next-state and pointer update for the clear pass.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    full_d  = full_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SCAN;
          src_d   = ROW_LAST;
          dst_d   = ROW_LAST;
          cnt_d   = 5'd0;
          col_d   = 4'd0;
          full_d  = 1'b1;
        end
      end
      S_SCAN: begin
        full_d = row_full;
        col_d  = col_q + 4'd1;
        if (col_end) begin
          col_d = 4'd0;
          if (row_full || (src_q == dst_q)) begin
            if (row_full) cnt_d = cnt_inc;
            else          dst_d = dst_q - 5'd1;
            src_d = src_q - 5'd1;
            if (src_q == 5'd0) begin
              // Last row handled: dst becomes the fill pointer (top cnt rows).
              state_d = (cnt_d != 5'd0) ? S_FILL : S_DONE;
              src_d   = 5'd0;
              dst_d   = (cnt_d != 5'd0) ? cnt_d - 5'd1 : 5'd0;
            end
          end else begin
            state_d = S_COPY;
          end
        end
      end
      S_COPY: begin
        col_d = col_q + 4'd1;
        if (col_end) begin
          col_d   = 4'd0;
          src_d   = src_q - 5'd1;
          dst_d   = dst_q - 5'd1;
          state_d = S_SCAN;
          if (src_q == 5'd0) begin
            state_d = (cnt_q != 5'd0) ? S_FILL : S_DONE;
            src_d   = 5'd0;
            dst_d   = (cnt_q != 5'd0) ? cnt_q - 5'd1 : 5'd0;
          end
        end
      end
      S_FILL: begin
        col_d = col_q + 4'd1;
        if (col_end) begin
          col_d = 4'd0;
          if (dst_q == 5'd0) state_d = S_DONE;
          else               dst_d   = dst_q - 5'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and pointer registers; reset aborts any pass in progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= 5'd0;
      dst_q   <= 5'd0;
      cnt_q   <= 5'd0;
      col_q   <= 4'd0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      full_q  <= full_d;
    end
  end

  assign in_scan = (state_q == S_SCAN);
  assign in_copy = (state_q == S_COPY);
  assign in_fill = (state_q == S_FILL);

  // Outputs are decoded from state so reset silences the write port at once.
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.lines_cleared = cnt_q;
  assign bus.board_rx      = (in_scan || in_copy) ? col_q : 4'd0;
  assign bus.board_ry      = (in_scan || in_copy) ? src_q : 5'd0;
  assign bus.board_we      = in_copy || in_fill;
  assign bus.board_wx      = (in_copy || in_fill) ? col_q : 4'd0;
  assign bus.board_wy      = (in_copy || in_fill) ? dst_q : 5'd0;
  assign bus.board_wdata   = in_copy & bus.board_rdata;

`ifdef LINE_CLEAR_SCORE_EN
  logic [7:0] score_q;
  logic [8:0] score_sum;

  assign score_sum = {1'b0, score_q} + {4'd0, cnt_q};

  // Add the finished pass's line count once, in the DONE cycle, saturating.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      score_q <= 8'd0;
    end else if (state_q == S_DONE) begin
      score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end

  assign bus.score = score_q;
`else
  assign bus.score = 8'd0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomized self-checking bench for line_clear_ctrl.
// Board memory lives here; expected boards, line counts, write counts and
// done latency come from a row-list reference model of the clear rules.
`timescale 1ns/1ps
module tb_line_clear_ctrl;
  logic CLOCK_50 = 1'b0;
  logic reset;

  line_clear_ctrl_if ifc();

  line_clear_ctrl dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (ifc)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [9:0] mem     [20];
  logic [9:0] img     [20];
  logic [9:0] exp_img [20];
  logic       load_req;
  int         wr_cnt = 0;

  int n_checks;
  int n_fails;
  int exp_score;
  int exp_lines;
  int exp_copies;

  assign ifc.board_rdata = (int'(ifc.board_ry) < 20 && int'(ifc.board_rx) < 10) ?
                           mem[ifc.board_ry][ifc.board_rx] : 1'b0;

  // Board storage: preload on request, otherwise honour the DUT write port.
  always @(posedge CLOCK_50) begin
    if (load_req) begin
      for (int y = 0; y < 20; y++) mem[y] <= img[y];
      wr_cnt <= 0;
    end else if (ifc.board_we) begin
      if (int'(ifc.board_wy) < 20 && int'(ifc.board_wx) < 10)
        mem[ifc.board_wy][ifc.board_wx] <= ifc.board_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, stack them at the
  // bottom, zero the rest. A non-full row needs a copy once any full row
  // has been removed beneath it.
  task automatic model_pass();
    int k;
    k          = 19;
    exp_lines  = 0;
    exp_copies = 0;
    for (int y = 19; y >= 0; y--) begin
      if (img[y] == 10'h3FF) exp_lines++;
      else begin
        if (exp_lines > 0) exp_copies++;
        exp_img[k] = img[y];
        k--;
      end
    end
    for (int y = k; y >= 0; y--) exp_img[y] = 10'h000;
  endtask

  task automatic load_board();
    load_req = 1'b1;
    @(posedge CLOCK_50);
    #1 load_req = 1'b0;
  endtask

  function automatic int idle_bus();
    return int'({ifc.board_rx, ifc.board_ry, ifc.board_wx, ifc.board_wy,
                 ifc.board_we, ifc.board_wdata});
  endfunction

  task automatic run_pass(input bit extra_start, input string name);
    int cyc, viol, bad_rows, exp_cyc;
    model_pass();
    load_board();
    exp_cyc = 201 + 10 * exp_copies + 10 * exp_lines;
    ifc.start = 1'b1;
    @(posedge CLOCK_50);
    #1 ifc.start = 1'b0;
    cyc  = 1;
    viol = 0;
    while (ifc.done !== 1'b1 && cyc < 1200) begin
      ifc.start = extra_start && (cyc == 50);
      if (!ifc.board_we && (ifc.board_wdata || ifc.board_wx != 0 || ifc.board_wy != 0)) viol++;
      if (ifc.busy !== 1'b1) viol++;
      @(posedge CLOCK_50);
      #1 cyc++;
    end
    ifc.start = 1'b0;
    check_eq({name, ":done_cycle"}, cyc, exp_cyc);
    check_eq({name, ":lines_cleared"}, int'(ifc.lines_cleared), exp_lines);
    check_eq({name, ":busy_in_done"}, int'(ifc.busy), 1);
    check_eq({name, ":write_port_gating"}, viol, 0);
    @(posedge CLOCK_50);
    #1;
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = (exp_score + exp_lines > 255) ? 255 : exp_score + exp_lines;
`endif
    check_eq({name, ":done_pulse_width"}, int'(ifc.done), 0);
    check_eq({name, ":busy_after"}, int'(ifc.busy), 0);
    check_eq({name, ":idle_bus"}, idle_bus(), 0);
    check_eq({name, ":score"}, int'(ifc.score), exp_score);
    check_eq({name, ":lines_held"}, int'(ifc.lines_cleared), exp_lines);
    bad_rows = 0;
    for (int y = 0; y < 20; y++) if (mem[y] !== exp_img[y]) bad_rows++;
    check_eq({name, ":board_bad_rows"}, bad_rows, 0);
    check_eq({name, ":write_cycles"}, wr_cnt, 10 * (exp_copies + exp_lines));
    repeat (3) @(posedge CLOCK_50);
    #1 check_eq({name, ":no_queued_start"}, int'(ifc.busy), 0);
  endtask

  task automatic random_board();
    for (int y = 0; y < 20; y++)
      img[y] = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
  endtask

  initial begin
    int cyc;
    int p0;
    n_checks  = 0;
    n_fails   = 0;
    exp_score = 0;
    reset     = 1'b1;
    ifc.start = 1'b0;
    load_req  = 1'b0;
    for (int y = 0; y < 20; y++) img[y] = 10'h000;

    #5;
    check_eq("reset:busy", int'(ifc.busy), 0);
    check_eq("reset:done", int'(ifc.done), 0);
    check_eq("reset:bus", idle_bus(), 0);
    check_eq("reset:lines", int'(ifc.lines_cleared), 0);
    check_eq("reset:score", int'(ifc.score), 0);
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;

    for (int y = 0; y < 20; y++) img[y] = 10'h000;
    run_pass(1'b0, "empty");

    for (int y = 0; y < 20; y++) img[y] = 10'h000;
    img[19] = 10'h3FF;
    img[18] = 10'h008;
    run_pass(1'b0, "one_line");

    for (int y = 0; y < 20; y++) img[y] = 10'h000;
    img[19] = 10'h3FF;
    img[17] = 10'h3FF;
    img[16] = 10'h3FF;
    img[15] = 10'h3FF;
    img[18] = 10'h001;
    run_pass(1'b1, "four_lines");

    for (int y = 0; y < 20; y++) img[y] = 10'h3FF;
    run_pass(1'b0, "full_board");

    for (int t = 0; t < 10; t++) begin
      random_board();
      run_pass(t[0], "random");
    end

    // Abort: extra start at cycle 50, reset at cycle 120 of a pass.
    random_board();
    load_board();
    ifc.start = 1'b1;
    @(posedge CLOCK_50);
    #1 ifc.start = 1'b0;
    cyc = 1;
    while (cyc < 120) begin
      ifc.start = (cyc == 50);
      @(posedge CLOCK_50);
      #1 cyc++;
    end
    ifc.start = 1'b0;
    check_eq("abort:busy_before_reset", int'(ifc.busy), 1);
    reset = 1'b1;
    #1;
    check_eq("abort:busy", int'(ifc.busy), 0);
    check_eq("abort:we", int'(ifc.board_we), 0);
    check_eq("abort:done", int'(ifc.done), 0);
    check_eq("abort:score", int'(ifc.score), 0);
    exp_score = 0;
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    random_board();
    run_pass(1'b0, "after_abort");

    // Repeated four-row passes drive the score accumulator to saturation.
    for (int p = 0; p < 64; p++) begin
      p0 = int'($urandom_range(0, 4));
      for (int y = 0; y < 20; y++)
        img[y] = (y % 5 == p0) ? 10'h3FF :
                 (10'($urandom_range(0, 1023)) & ~(10'd1 << $urandom_range(0, 9)));
      run_pass(1'b0, "score");
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end
endmodule
